// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Stall/flush controller for the five-stage core. Merges the ID
//             load-use hazard, the MEM flush and the multi-cycle (HI/LO
//             divider) sequencing into one stall vector, drives the
//             start/cancel handshake of the multi-cycle unit with a watchdog,
//             and keeps a saturating stalled-cycle counter.
//  Ports    : clk, rst_n         clock, asynchronous active-low reset
//             stallreq_id        load-use hazard from ID
//             mc_req / mc_done   multi-cycle op in EX / unit result ready
//             flush_req          exception/redirect flush from MEM
//             cnt_clr            synchronous clear of stall_cnt
//             stall[5:0]         {rsvd, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
//             flush              flush all stage registers
//             mc_start/mc_cancel one-cycle pulses to the multi-cycle unit
//             mc_valid/mc_timeout result consumable / result timed out
//             busy               sequencer not idle
//             stall_cnt[31:0]    saturating count of stalled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id,
    input  logic        mc_req,
    input  logic        mc_done,
    input  logic        flush_req,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        mc_start,
    output logic        mc_cancel,
    output logic        mc_valid,
    output logic        mc_timeout,
    output logic        busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  c_WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;
    localparam logic [5:0]  c_STALL_MC  = 6'b001111;  // PC..EX/MEM frozen, MEM/WB takes a bubble
    localparam logic [5:0]  c_STALL_LU  = 6'b000111;  // PC..ID/EX frozen

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wd;
    logic [7:0]  w_wd_nxt;
    logic        r_to;
    logic        w_to_nxt;
    logic [31:0] r_stall_cnt;

    logic        w_start;
    logic        w_cancel;
    logic        w_valid;
    logic        w_tmo;
    logic [5:0]  w_stall;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wd    <= 8'd0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle sequencer: next state and handshake pulses
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_to_nxt    = r_to;
        w_start     = 1'b0;
        w_cancel    = 1'b0;
        w_valid     = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A flushed instruction must never launch the unit.
                if (!flush_req && mc_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_wd_nxt    = 8'd0;
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    w_cancel    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (mc_done) begin
                    // Done beats a simultaneous watchdog expiry.
                    w_state_nxt = ST_DONE;
                end else if (r_wd == c_WD_LAST) begin
                    w_cancel    = 1'b1;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_wd_nxt    = r_wd + 8'd1;
                end
            end
            ST_DONE: begin
                // mc_req is still high here for the same instruction; ignore it.
                w_valid     = 1'b1;
                w_tmo       = r_to;
                w_to_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall vector: flush first, then multi-cycle occupancy, then load-use.
    // Depends only on state and request inputs, never on mc_done.
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = 6'b000000;
        if (flush_req) begin
            w_stall = 6'b000000;
        end else if ((r_state == ST_IDLE && mc_req) || r_state == ST_RUN) begin
            w_stall = c_STALL_MC;
        end else if (stallreq_id) begin
            w_stall = c_STALL_LU;
        end
    end

    // ------------------------------------------------------------------
    // Stalled-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (cnt_clr) begin
            r_stall_cnt <= 32'd0;
        end else if (stall != 6'b000000 && r_stall_cnt != c_CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Combinational outputs are held at zero while reset is asserted, so
    // inputs toggling during reset never reach the pipeline.
    assign stall      = rst_n ? w_stall : 6'b000000;
    assign flush      = rst_n & flush_req;
    assign mc_start   = rst_n & w_start;
    assign mc_cancel  = rst_n & w_cancel;
    assign mc_valid   = rst_n & w_valid;
    assign mc_timeout = rst_n & w_tmo;
    assign busy       = rst_n & (r_state != ST_IDLE);
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Directed self-checking bench for pipe_ctrl. Two instances are
//             built: one with TIMEOUT=64 (divide, flush, counter checks) and
//             one with TIMEOUT=4 (watchdog checks). A select routes the
//             stimulus to one instance while the other sees idle inputs.
//             Each step pushes its expected outputs into a queue and pops
//             them for comparison on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam logic [5:0] S_NONE   = 6'b000000;
    localparam logic [5:0] S_LU     = 6'b000111;
    localparam logic [5:0] S_MC     = 6'b001111;
    // flag order: {flush, mc_start, mc_cancel, mc_valid, mc_timeout, busy}
    localparam logic [5:0] F_0      = 6'b000000;
    localparam logic [5:0] F_FLUSH  = 6'b100000;
    localparam logic [5:0] F_START  = 6'b010000;
    localparam logic [5:0] F_CANCEL = 6'b001000;
    localparam logic [5:0] F_VALID  = 6'b000100;
    localparam logic [5:0] F_TMO    = 6'b000010;
    localparam logic [5:0] F_BUSY   = 6'b000001;

    typedef struct {
        string       tag;
        logic [43:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        sid, req, done, fl, clr;
    logic [4:0]  in_a, in_b;

    assign in_a = sel ? 5'b00000 : {sid, req, done, fl, clr};
    assign in_b = sel ? {sid, req, done, fl, clr} : 5'b00000;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b, start_a, start_b, cancel_a, cancel_b;
    logic        valid_a, valid_b, tmo_a, tmo_b, busy_a, busy_b;
    logic [31:0] cnt_a, cnt_b;

    pipe_ctrl #(.TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_id(in_a[4]), .mc_req(in_a[3]), .mc_done(in_a[2]),
        .flush_req(in_a[1]), .cnt_clr(in_a[0]),
        .stall(stall_a), .flush(flush_a), .mc_start(start_a),
        .mc_cancel(cancel_a), .mc_valid(valid_a), .mc_timeout(tmo_a),
        .busy(busy_a), .stall_cnt(cnt_a)
    );

    pipe_ctrl #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .stallreq_id(in_b[4]), .mc_req(in_b[3]), .mc_done(in_b[2]),
        .flush_req(in_b[1]), .cnt_clr(in_b[0]),
        .stall(stall_b), .flush(flush_b), .mc_start(start_b),
        .mc_cancel(cancel_b), .mc_valid(valid_b), .mc_timeout(tmo_b),
        .busy(busy_b), .stall_cnt(cnt_b)
    );

    exp_t        sb[$];
    logic [31:0] exp_cnt[2];
    int          vectors;
    int          miscompares;

    function automatic logic [43:0] observe();
        if (sel)
            return {stall_b, flush_b, start_b, cancel_b, valid_b, tmo_b, busy_b, cnt_b};
        return {stall_a, flush_a, start_a, cancel_a, valid_a, tmo_a, busy_a, cnt_a};
    endfunction

    // One clock cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input string tag,
                        input logic a_sid, input logic a_req, input logic a_done,
                        input logic a_fl, input logic a_clr,
                        input logic [5:0] e_stall, input logic [5:0] e_flags);
        exp_t        e;
        logic [43:0] got;
        @(posedge clk);
        #1;
        sid  = a_sid;
        req  = a_req;
        done = a_done;
        fl   = a_fl;
        clr  = a_clr;
        e.tag = tag;
        e.val = {e_stall, e_flags, exp_cnt[sel]};
        sb.push_back(e);
        if (a_clr)
            exp_cnt[sel] = 32'd0;
        else if (e_stall != 6'b000000 && exp_cnt[sel] != 32'hFFFF_FFFF)
            exp_cnt[sel] = exp_cnt[sel] + 32'd1;
        @(negedge clk);
        e   = sb.pop_front();
        got = observe();
        vectors++;
        assert (got === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt[0]  = 32'd0;
        exp_cnt[1]  = 32'd0;
        sel  = 1'b0;
        sid  = 1'b0; req = 1'b0; done = 1'b0; fl = 1'b0; clr = 1'b0;
        rst_n = 1'b0;

        // Reset held with every input high: outputs forced to zero.
        step("rst_hold0", 1, 1, 1, 1, 1, S_NONE, F_0);
        step("rst_hold1", 1, 1, 1, 1, 1, S_NONE, F_0);
        sid = 1'b0; req = 1'b0; done = 1'b0; fl = 1'b0; clr = 1'b0;
        rst_n = 1'b1;
        step("rst_rel0", 0, 0, 0, 0, 0, S_NONE, F_0);
        step("rst_rel1", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Load-use hazard for two cycles, then count visible, then clear.
        step("lu0", 1, 0, 0, 0, 0, S_LU, F_0);
        step("lu1", 1, 0, 0, 0, 0, S_LU, F_0);
        step("lu_cnt2", 0, 0, 0, 0, 1, S_NONE, F_0);
        step("lu_clr", 0, 0, 0, 0, 0, S_NONE, F_0);

        // mc_done outside RUN has no effect.
        step("done_idle", 0, 0, 1, 0, 0, S_NONE, F_0);

        // Divide on TIMEOUT=64; load-use raised with mc_req at cycle 0.
        step("prio_start", 1, 1, 0, 0, 0, S_MC, F_START);
        for (int c = 1; c <= 32; c++)
            step("div_run", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("div_done_in", 0, 1, 1, 0, 0, S_MC, F_BUSY);
        step("div_valid", 0, 1, 0, 0, 0, S_NONE, F_VALID | F_BUSY);
        step("div_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Back-to-back: second request accepted in the IDLE cycle after DONE.
        step("b2b_start1", 0, 1, 0, 0, 0, S_MC, F_START);
        step("b2b_run1", 0, 1, 1, 0, 0, S_MC, F_BUSY);
        step("b2b_done1", 1, 1, 0, 0, 0, S_LU, F_VALID | F_BUSY);
        step("b2b_start2", 0, 1, 0, 0, 0, S_MC, F_START);
        step("b2b_run2", 0, 1, 1, 0, 0, S_MC, F_BUSY);
        step("b2b_done2", 0, 1, 0, 0, 0, S_NONE, F_VALID | F_BUSY);
        step("b2b_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Flush in IDLE blocks a start.
        step("fl_idle", 0, 1, 0, 1, 0, S_NONE, F_FLUSH);
        step("fl_idle_after", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Flush on the third RUN cycle.
        step("flr_start", 0, 1, 0, 0, 0, S_MC, F_START);
        step("flr_run1", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("flr_run2", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("flr_run3", 0, 1, 0, 1, 0, S_NONE, F_FLUSH | F_CANCEL | F_BUSY);
        step("flr_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Saturation: preload near the top, hold a stall.
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        exp_cnt[0] = 32'hFFFF_FFFE;
        step("sat0", 1, 0, 0, 0, 0, S_LU, F_0);
        step("sat1", 1, 0, 0, 0, 0, S_LU, F_0);
        step("sat2", 1, 0, 0, 0, 0, S_LU, F_0);
        step("sat3", 0, 0, 0, 0, 1, S_NONE, F_0);
        step("sat_clr", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Watchdog on the TIMEOUT=4 instance.
        sel = 1'b1;
        step("wd_start", 0, 1, 0, 0, 0, S_MC, F_START);
        step("wd_run1", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wd_run2", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wd_run3", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wd_run4", 0, 1, 0, 0, 0, S_MC, F_BUSY | F_CANCEL);
        step("wd_valid", 0, 1, 0, 0, 0, S_NONE, F_VALID | F_TMO | F_BUSY);
        step("wd_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Done on the last watchdog cycle wins.
        step("wdd_start", 0, 1, 0, 0, 0, S_MC, F_START);
        step("wdd_run1", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdd_run2", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdd_run3", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdd_run4", 0, 1, 1, 0, 0, S_MC, F_BUSY);
        step("wdd_valid", 0, 1, 0, 0, 0, S_NONE, F_VALID | F_BUSY);
        step("wdd_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Timeout then flush in DONE: flag still reported, FSM returns IDLE.
        step("wdf_start", 0, 1, 0, 0, 0, S_MC, F_START);
        step("wdf_run1", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdf_run2", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdf_run3", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        step("wdf_run4", 0, 1, 0, 0, 0, S_MC, F_BUSY | F_CANCEL);
        step("wdf_done", 0, 1, 0, 1, 0, S_NONE, F_FLUSH | F_VALID | F_TMO | F_BUSY);
        step("wdf_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        // Reset in the middle of RUN returns to IDLE with no cancel.
        step("rr_start", 0, 1, 0, 0, 0, S_MC, F_START);
        step("rr_run1", 0, 1, 0, 0, 0, S_MC, F_BUSY);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_cnt[1] = 32'd0;
        step("rr_idle", 0, 0, 0, 0, 0, S_NONE, F_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. Merges hazard and flush requests from the stages into one stall vector that freezes the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Sequences the multi-cycle HI/LO unit (divider) with a start/done handshake, guarded by a watchdog. Keeps a saturating stalled-cycle performance counter.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles in RUN before the watchdog fires; legal range 2..255.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stallreq_id` in 1: load-use hazard from ID; combinational, same cycle.
- `mc_req` in 1: EX holds a multi-cycle op; stays high while that instruction sits in EX.
- `mc_done` in 1: multi-cycle unit has its result ready; sampled in RUN only.
- `flush_req` in 1: exception/redirect flush request from MEM.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- `flush` out 1: flush all stage registers this cycle.
- `mc_start` out 1: one-cycle start pulse to the multi-cycle unit.
- `mc_cancel` out 1: one-cycle abort pulse to the multi-cycle unit.
- `mc_valid` out 1: result of the multi-cycle unit may be consumed by EX this cycle.
- `mc_timeout` out 1: qualifies `mc_valid`; result is invalid because the watchdog fired.
- `busy` out 1: FSM is not IDLE.
- `stall_cnt` out 32: saturating count of cycles with `stall != 0`.

## Operation
- FSM states: IDLE, RUN, DONE (2-bit register). Watchdog counter `wd` is 8 bits wide.
- IDLE:
  - `flush_req`: no start; stay IDLE.
  - else `mc_req`: `mc_start`=1, go RUN, clear `wd`.
- RUN:
  - `flush_req`: `mc_cancel`=1, go IDLE.
  - else `mc_done`: go DONE.
  - else `wd == TIMEOUT-1`: `mc_cancel`=1, set the internal timeout flag, go DONE.
  - else increment `wd`.
- DONE:
  - `mc_valid`=1 for exactly this one cycle; `mc_timeout` equals the timeout flag.
  - `mc_req` is ignored, because the same instruction is still in EX.
  - Clear the timeout flag and go IDLE, whether or not `flush_req` is set.
- Stall vector, combinational, first match wins:
  - `flush_req` → 000000, and `flush`=1.
  - (IDLE and `mc_req`) or RUN → 001111 (PC through EX/MEM frozen; MEM/WB advances and inserts a bubble).
  - `stallreq_id` → 000111.
  - otherwise 000000.
- In DONE, `stallreq_id` still applies: 000111 if asserted, else 000000.
- `flush` = `flush_req` (pass-through, all states).
- `busy` = (state != IDLE).
- `stall_cnt`:
  - `cnt_clr` wins and sets it to 0.
  - else it increments when `stall != 0`, saturating at 0xFFFFFFFF.

## Timing
- All outputs are 0 while `rst_n`=0 and after its release: state IDLE, `wd`=0, timeout flag 0, `stall_cnt`=0.
- `rst_n` assertion mid-RUN returns to IDLE immediately. No `mc_cancel` is issued; the multi-cycle unit is reset by the same `rst_n`.
- `mc_start` is asserted in the same cycle that `mc_req` is first seen in IDLE, with no added latency.
- Minimum multi-cycle occupancy: start cycle + 1 RUN cycle + 1 DONE cycle. EX is frozen for cycles 0..N and released in DONE.
- Watchdog: with no `mc_done`, the FSM is in RUN for exactly `TIMEOUT` cycles, then DONE with `mc_timeout`=1.
- `mc_done` in the same cycle as `wd == TIMEOUT-1`: done wins, so `mc_timeout`=0 and there is no `mc_cancel`.
- `mc_done` outside RUN is ignored.
- Back-to-back multi-cycle ops: the second `mc_req` is accepted in the IDLE cycle following DONE.
- `mc_start`, `mc_cancel`, `stall` and `flush` are combinational from state and inputs. No combinational path from `mc_done` to `stall`.

## Test plan
- Reset: hold `rst_n`=0 with all inputs at 1 → every output 0. Release `rst_n` with inputs at 0 → outputs stay 0 and `stall_cnt`=0.
- Load-use: `stallreq_id`=1 for 2 cycles → `stall`=000111 for 2 cycles, `stall_cnt`=2. Then `cnt_clr`=1 → `stall_cnt`=0.
- Divide, `TIMEOUT`=64: `mc_req` rises at cycle 0, `mc_done` pulses at cycle 33 →
  - `mc_start` high at cycle 0 only.
  - `stall`=001111 for cycles 0..33.
  - DONE at cycle 34 with `mc_valid`=1, `mc_timeout`=0, `stall`=0.
  - IDLE at cycle 35.
- Watchdog, `TIMEOUT`=4: `mc_req` held and `mc_done` never asserted → RUN for 4 cycles, `mc_cancel` on the 4th, then DONE with `mc_valid`=1 and `mc_timeout`=1. Repeat with `mc_done` on that 4th cycle → `mc_timeout`=0, no `mc_cancel`.
- Flush mid-RUN: `flush_req` on the 3rd RUN cycle → in that cycle `mc_cancel`=1, `flush`=1, `stall`=000000. Next cycle IDLE with `busy`=0.
- Saturation and priority: preload `stall_cnt` to 0xFFFFFFFE via a forced-state bench and hold a stall → counter sticks at 0xFFFFFFFF. `stallreq_id`=1 together with `mc_req`=1 in IDLE → `stall`=001111.
